seg_scan_decoder: RTL

- Receive-side counterpart of the 8-digit seven-segment display driver.
- Samples a time-multiplexed display bus (shared active-low segment lines plus a one-hot digit select), debounces each digit slot and decodes each pattern to a character code.
- Reassembles the 8-digit frame, recovers the per-digit enable mask, and checks the frame against the fixed "AAUB2225" message.
- Sits on board-test and loopback paths, observing the display drive.

---
 rtl/seg_scan_decoder_if.sv | 24 ++
 rtl/seg_scan_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder_if.sv
// Display-bus and decoded-frame signals of the seven-segment scan decoder.
// The master side drives the display bus; the slave side is the decoder.
interface seg_scan_decoder_if;
  logic [6:0]  seg;
  logic [7:0]  dig_sel;
  logic [31:0] frame;
  logic [7:0]  ctrl_rec;
  logic        frame_valid;
  logic        match;
  logic        err;
  logic        timeout;

  // frame_valid is a one-cycle strobe with no back-pressure: frame, ctrl_rec and
  // match are valid only while it is high; err and timeout are one-cycle strobes.
  modport master (
    output seg, dig_sel,
    input  frame, ctrl_rec, frame_valid, match, err, timeout
  );

  modport slave (
    input  seg, dig_sel,
    output frame, ctrl_rec, frame_valid, match, err, timeout
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment bus, debounces each digit slot, decodes it,
// and reassembles the 8-digit frame checked against the "AAUB2225" message.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_decoder_if.slave bus,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
  // Expected code per digit, digit 0 in the low nibble.
  localparam logic [31:0]   EXP_CODES  = 32'h5444_1233;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  function automatic logic [3:0] decode(input logic [6:0] s);
    logic [3:0] c;
    case (s)
      7'b1111111: c = 4'h0;
      7'b0000000: c = 4'h1;
      7'b1000001: c = 4'h2;
      7'b0001000: c = 4'h3;
      7'b0100100: c = 4'h4;
      7'b0010010: c = 4'h5;
      default:    c = 4'hF;
    endcase
    return c;
  endfunction

  logic [6:0]    seg_q, seg_d, seg_p_q, seg_p_d;
  logic [7:0]    sel_q, sel_d, sel_p_q, sel_p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   slots_q, slots_d;
  logic [7:0]    mask_q, mask_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_t        state_q, state_d;
  logic [31:0]   frame_q, frame_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic          match_q, match_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  logic          sel_legal;
  logic          sel_multi;
  logic          same;
  logic          capture;
  logic [3:0]    code;
  logic [7:0]    mask_cap;
  logic [7:0]    ctrl_calc;
  logic          match_calc;
  logic [TW-1:0] tmo_inc;

  // Input stage and debounce counter.
  always_comb begin
    seg_d     = bus.seg;
    sel_d     = bus.dig_sel;
    seg_p_d   = seg_q;
    sel_p_d   = sel_q;
    sel_legal = (sel_q != 8'd0) && ((sel_q & (sel_q - 8'd1)) == 8'd0);
    sel_multi = (sel_q != 8'd0) && !sel_legal;
    same      = (seg_q == seg_p_q) && (sel_q == sel_p_q);
    err_d     = sel_multi;
    cnt_d     = '0;
    if (!sel_legal) begin
      cnt_d = '0;
    end else if (same) begin
      cnt_d = (cnt_q == STABLE_MAX) ? STABLE_MAX : cnt_q + CW'(1);
    end else begin
      cnt_d = CW'(1);
    end
    // A saturated counter means this run was already captured.
    capture  = sel_legal && (cnt_d == STABLE_MAX) && (cnt_q != STABLE_MAX);
    code     = decode(seg_q);
    mask_cap = capture ? sel_q : 8'd0;
  end

  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < 8; i++) begin
      if (mask_cap[i]) slots_d[4*i +: 4] = code;
    end
  end

  // Unknown code F never equals an expected code, so it clears match here.
  always_comb begin
    ctrl_calc  = 8'd0;
    match_calc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ctrl_calc[7-i] = (slots_d[4*i +: 4] != 4'h0);
      if ((slots_d[4*i +: 4] != 4'h0) && (slots_d[4*i +: 4] != EXP_CODES[4*i +: 4]))
        match_calc = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    tmo_d     = '0;
    frame_d   = frame_q;
    ctrl_d    = ctrl_q;
    match_d   = match_q;
    timeout_d = 1'b0;
    tmo_inc   = tmo_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        mask_d = mask_cap;
        if (capture) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        mask_d = mask_q | mask_cap;
        if (mask_d == 8'hFF) begin
          state_d = S_EMIT;
          frame_d = slots_d;
          ctrl_d  = ctrl_calc;
          match_d = match_calc;
        end else if (capture) begin
          tmo_d = '0;
        end else if (tmo_inc == TMO_MAX) begin
          timeout_d = 1'b1;
          mask_d    = 8'd0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_EMIT: begin
        // A capture landing on the emit cycle seeds the next frame.
        mask_d  = mask_cap;
        state_d = capture ? S_COLLECT : S_IDLE;
      end
      default: begin
        mask_d  = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q     <= '0;
      sel_q     <= '0;
      seg_p_q   <= '0;
      sel_p_q   <= '0;
      cnt_q     <= '0;
      slots_q   <= '0;
      mask_q    <= '0;
      tmo_q     <= '0;
      state_q   <= S_IDLE;
      frame_q   <= '0;
      ctrl_q    <= '0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      seg_p_q   <= seg_p_d;
      sel_p_q   <= sel_p_d;
      cnt_q     <= cnt_d;
      slots_q   <= slots_d;
      mask_q    <= mask_d;
      tmo_q     <= tmo_d;
      state_q   <= state_d;
      frame_q   <= frame_d;
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.frame       = frame_q;
  assign bus.ctrl_rec    = ctrl_q;
  assign bus.frame_valid = (state_q == S_EMIT);
  assign bus.match       = match_q;
  assign bus.err         = err_q;
  assign bus.timeout     = timeout_q;
  assign dbg_state       = state_q;

endmodule
